// File: rtl/soc_boot_seq_pkg.sv
// Boot sequencer shared types: FSM states, register map, CTRL/STATUS bits.
// Imported by soc_system_boot_sequencer and soc_boot_seq_timer.
package soc_boot_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HOLD     = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_DONE     = 3'd3,
    ST_TMO      = 3'd4
  } boot_state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_HOLD   = 2'd2;
  localparam logic [1:0] ADDR_TMO    = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_CLR   = 2;

  localparam int STAT_DONE     = 4;
  localparam int STAT_TIMEOUT  = 5;
  localparam int STAT_ABORTED  = 6;
  localparam int STAT_IRQ_MASK = 8;

endpackage

// File: rtl/soc_boot_seq_timer.sv
// Loadable W-bit down-counter that holds at zero.
// Ports: clk, reset, load, load_val, en (decrement), zero (count==0).
module soc_boot_seq_timer
  import soc_boot_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/soc_system_boot_sequencer.sv
// Avalon-MM boot-line sequencer: hold, request, ack/timeout; irq with SOC_BOOT_SEQ_IRQ_EN.
// Ports: clk, reset, address, chipselect, write_n, writedata, readdata, boot_ack, boot_hold, boot_req, irq.
module soc_system_boot_sequencer
  import soc_boot_seq_pkg::*;
#(
  parameter int             CNT_W    = 16,
  parameter logic [CNT_W-1:0] HOLD_RST = CNT_W'(64),
  parameter logic [CNT_W-1:0] TMO_RST  = CNT_W'(0)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        boot_ack,
  output logic        boot_hold,
  output logic        boot_req,
  output logic        irq
);

  boot_state_t      state;
  logic [CNT_W-1:0] hold_reg;
  logic [CNT_W-1:0] tmo_reg;
  logic             st_done;
  logic             st_tmo;
  logic             st_abort;
  logic             irq_mask;
  logic             tmo_armed;

  logic wr_en;
  logic ctrl_wr;
  logic start;
  logic abort;
  logic clr;
  logic in_run;
  logic do_abort;

  assign wr_en   = chipselect && !write_n;
  assign ctrl_wr = wr_en && (address == ADDR_CTRL);
  assign start   = ctrl_wr && writedata[CTRL_START];
  assign abort   = ctrl_wr && writedata[CTRL_ABORT];
  assign clr     = ctrl_wr && writedata[CTRL_CLR];

  assign in_run   = (state == ST_HOLD) || (state == ST_WAIT_ACK);
  assign do_abort = abort && in_run;

  // Counters are loaded with N-1 so that zero marks the final cycle.
  logic [CNT_W-1:0] hold_ld_val;
  logic [CNT_W-1:0] tmo_ld_val;
  logic             hold_load;
  logic             hold_en;
  logic             hold_zero;
  logic             hold_exit;
  logic             tmo_en;
  logic             tmo_zero;

  assign hold_ld_val = (hold_reg == '0) ? '0 : hold_reg - CNT_W'(1);
  assign tmo_ld_val  = (tmo_reg == '0) ? '0 : tmo_reg - CNT_W'(1);

  assign hold_load = start && !in_run && !clr;
  assign hold_en   = (state == ST_HOLD) && !do_abort;
  assign hold_exit = hold_en && hold_zero;
  assign tmo_en    = (state == ST_WAIT_ACK) && !do_abort;

  soc_boot_seq_timer #(.W(CNT_W)) u_hold_tmr (
    .clk      (clk),
    .reset    (reset),
    .load     (hold_load),
    .load_val (hold_ld_val),
    .en       (hold_en),
    .zero     (hold_zero)
  );

  soc_boot_seq_timer #(.W(CNT_W)) u_tmo_tmr (
    .clk      (clk),
    .reset    (reset),
    .load     (hold_exit),
    .load_val (tmo_ld_val),
    .en       (tmo_en),
    .zero     (tmo_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_reg <= HOLD_RST;
      tmo_reg  <= TMO_RST;
    end else if (wr_en) begin
      if (address == ADDR_HOLD) hold_reg <= writedata[CNT_W-1:0];
      if (address == ADDR_TMO)  tmo_reg  <= writedata[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      boot_hold <= 1'b0;
      boot_req  <= 1'b0;
      st_done   <= 1'b0;
      st_tmo    <= 1'b0;
      st_abort  <= 1'b0;
      tmo_armed <= 1'b0;
    end else if (do_abort) begin
      state     <= ST_IDLE;
      boot_hold <= 1'b0;
      boot_req  <= 1'b0;
      st_abort  <= 1'b1;
    end else begin
      // Status clear first so a same-cycle DONE/TMO set still lands.
      if (clr) begin
        st_done  <= 1'b0;
        st_tmo   <= 1'b0;
        st_abort <= 1'b0;
      end
      case (state)
        ST_IDLE, ST_DONE, ST_TMO: begin
          if (clr) begin
            state <= ST_IDLE;
          end else if (start) begin
            state     <= ST_HOLD;
            boot_hold <= 1'b1;
            st_done   <= 1'b0;
            st_tmo    <= 1'b0;
            st_abort  <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (hold_zero) begin
            state     <= ST_WAIT_ACK;
            boot_hold <= 1'b0;
            boot_req  <= 1'b1;
            tmo_armed <= (tmo_reg != '0);
          end
        end
        ST_WAIT_ACK: begin
          if (boot_ack) begin
            state    <= ST_DONE;
            boot_req <= 1'b0;
            st_done  <= 1'b1;
          end else if (tmo_armed && tmo_zero) begin
            state    <= ST_TMO;
            boot_req <= 1'b0;
            st_tmo   <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          boot_hold <= 1'b0;
          boot_req  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SOC_BOOT_SEQ_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr_en && (address == ADDR_STATUS))
        irq_mask <= writedata[STAT_IRQ_MASK];
      irq <= irq_mask && (st_done || st_tmo || st_abort);
    end
  end
`else
  assign irq_mask = 1'b0;
  assign irq      = 1'b0;
`endif

  logic [31:0] status_word;

  always_comb begin
    status_word                = '0;
    status_word[2:0]           = state;
    status_word[STAT_DONE]     = st_done;
    status_word[STAT_TIMEOUT]  = st_tmo;
    status_word[STAT_ABORTED]  = st_abort;
    status_word[STAT_IRQ_MASK] = irq_mask;
  end

  always_comb begin
    readdata = '0;
    unique case (1'b1)
      (address == ADDR_STATUS): readdata = status_word;
      (address == ADDR_HOLD):   readdata = 32'(hold_reg);
      (address == ADDR_TMO):    readdata = 32'(tmo_reg);
      default:                  readdata = '0;
    endcase
  end

  logic unused_wdata;
  assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_soc_system_boot_sequencer.sv
// Directed self-checking bench for soc_system_boot_sequencer.
// Register table vectors followed by multi-cycle boot sequences.
module tb_soc_system_boot_sequencer;

`ifdef SOC_BOOT_SEQ_IRQ_EN
  localparam logic [31:0] MASKBIT = 32'h100;
  localparam logic        IRQ_ON  = 1'b1;
`else
  localparam logic [31:0] MASKBIT = 32'h0;
  localparam logic        IRQ_ON  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        boot_ack = 1'b0;
  logic        boot_hold;
  logic        boot_req;
  logic        irq;

  soc_system_boot_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .boot_ack   (boot_ack),
    .boot_hold  (boot_hold),
    .boot_req   (boot_req),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        wr;
    logic        cs;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic cs, input logic [1:0] a,
                    input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = cs;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic count_hold(output int n);
    n = 0;
    while (boot_hold && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic count_req(output int n);
    n = 0;
    while (boot_req && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  logic [31:0] rv;
  int          n;

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 2'd0, 32'h0,         32'h0};
    vecs[1]  = '{1'b0, 1'b0, 2'd1, 32'h0,         32'h0};
    vecs[2]  = '{1'b0, 1'b0, 2'd2, 32'h0,         32'd64};
    vecs[3]  = '{1'b0, 1'b0, 2'd3, 32'h0,         32'h0};
    vecs[4]  = '{1'b1, 1'b1, 2'd2, 32'h1234_0007, 32'h7};
    vecs[5]  = '{1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'hFFFF};
    vecs[6]  = '{1'b1, 1'b0, 2'd2, 32'h0000_AAAA, 32'h7};
    vecs[7]  = '{1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF, MASKBIT};
    vecs[8]  = '{1'b1, 1'b1, 2'd1, 32'h0,         32'h0};
    vecs[9]  = '{1'b1, 1'b1, 2'd0, 32'h0,         32'h0};
    vecs[10] = '{1'b1, 1'b1, 2'd2, 32'h0,         32'h0};
    vecs[11] = '{1'b1, 1'b1, 2'd3, 32'h0,         32'h0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_hold", 32'(boot_hold), 32'h0);
    chk("rst_req",  32'(boot_req),  32'h0);
    chk("rst_irq",  32'(irq),       32'h0);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) wr(vecs[i].cs, vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, rv);
      chk($sformatf("vec%0d", i), rv, vecs[i].exp);
    end

    // 1: HOLD=5, ack three cycles after req
    wr(1, 2'd2, 32'd5);
    wr(1, 2'd3, 32'd0);
    wr(1, 2'd0, 32'h1);
    count_hold(n);
    chk("t1_hold_len", 32'(n), 32'd5);
    chk("t1_req_up", 32'(boot_req), 32'h1);
    repeat (2) @(negedge clk);
    rd(2'd1, rv);
    chk("t1_waiting", rv, 32'h2);
    boot_ack = 1'b1;
    @(negedge clk);
    boot_ack = 1'b0;
    chk("t1_req_low", 32'(boot_req), 32'h0);
    rd(2'd1, rv);
    chk("t1_status", rv, 32'h13);

    // 2: HOLD=0 behaves as one cycle
    wr(1, 2'd2, 32'd0);
    wr(1, 2'd0, 32'h1);
    count_hold(n);
    chk("t2_hold_len", 32'(n), 32'd1);
    chk("t2_req_up", 32'(boot_req), 32'h1);
    boot_ack = 1'b1;
    @(negedge clk);
    boot_ack = 1'b0;
    rd(2'd1, rv);
    chk("t2_status", rv, 32'h13);

    // 3: timeout after 10 request cycles
    wr(1, 2'd1, 32'h100);
    wr(1, 2'd2, 32'd2);
    wr(1, 2'd3, 32'd10);
    wr(1, 2'd0, 32'h1);
    count_hold(n);
    chk("t3_hold_len", 32'(n), 32'd2);
    count_req(n);
    chk("t3_req_len", 32'(n), 32'd10);
    rd(2'd1, rv);
    chk("t3_status", rv, MASKBIT | 32'h24);
    chk("t3_irq_lag", 32'(irq), 32'h0);
    @(negedge clk);
    chk("t3_irq", 32'(irq), 32'(IRQ_ON));

    // 4: abort in hold cycle 3 of 8, then abort in idle
    wr(1, 2'd2, 32'd8);
    wr(1, 2'd0, 32'h1);
    repeat (2) @(negedge clk);
    chk("t4_hold_c3", 32'(boot_hold), 32'h1);
    wr(1, 2'd0, 32'h2);
    chk("t4_hold_drop", 32'(boot_hold), 32'h0);
    rd(2'd1, rv);
    chk("t4_status", rv, MASKBIT | 32'h40);
    wr(1, 2'd0, 32'h2);
    rd(2'd1, rv);
    chk("t4_abort_idle", rv, MASKBIT | 32'h40);
    chk("t4_outs", {30'h0, boot_hold, boot_req}, 32'h0);

    // 5: ack on final timeout cycle wins, then CLR
    wr(1, 2'd2, 32'd1);
    wr(1, 2'd3, 32'd4);
    wr(1, 2'd0, 32'h1);
    count_hold(n);
    chk("t5_hold_len", 32'(n), 32'd1);
    repeat (3) @(negedge clk);
    chk("t5_req_c4", 32'(boot_req), 32'h1);
    boot_ack = 1'b1;
    @(negedge clk);
    boot_ack = 1'b0;
    rd(2'd1, rv);
    chk("t5_status", rv, MASKBIT | 32'h13);
    wr(1, 2'd0, 32'h4);
    rd(2'd1, rv);
    chk("t5_clr", rv, MASKBIT);

    // 6: START ignored mid-run, then async reset
    wr(1, 2'd2, 32'd3);
    wr(1, 2'd3, 32'd0);
    wr(1, 2'd0, 32'h1);
    count_hold(n);
    chk("t6_hold_len", 32'(n), 32'd3);
    wr(1, 2'd0, 32'h1);
    rd(2'd1, rv);
    chk("t6_restart", rv, MASKBIT | 32'h2);
    chk("t6_req_kept", 32'(boot_req), 32'h1);
    reset = 1'b1;
    #1;
    chk("t6_rst_outs", {29'h0, boot_hold, boot_req, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rd(2'd2, rv);
    chk("t6_hold_rst", rv, 32'd64);
    rd(2'd3, rv);
    chk("t6_tmo_rst", rv, 32'd0);
    rd(2'd1, rv);
    chk("t6_status_rst", rv, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
